// File: rtl/hazard_if.sv
// ---------------------------------------------------------------------------
// hazard_if -- decode-stage <-> hazard tracker signal bundle.
//
// master : decode/issue side; drives the issuing instruction, the source
//          operands of the instruction in decode, register-file read data,
//          the in-flight stage results and flush. It receives the stall
//          request, the forwarded operands and the stall counter.
// slave  : hazard_tracker side (directions inverted).
// ---------------------------------------------------------------------------
interface hazard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
);
    logic                    issue_valid;
    logic [ADDR_W-1:0]       issue_rd;
    logic                    issue_we;
    logic                    issue_is_load;
    logic [ADDR_W-1:0]       rs_addr;
    logic [ADDR_W-1:0]       rt_addr;
    logic                    rs_used;
    logic                    rt_used;
    logic [DATA_W-1:0]       rf_rs_data;
    logic [DATA_W-1:0]       rf_rt_data;
    logic [DEPTH*DATA_W-1:0] stage_data;
    logic                    flush;
    logic                    stall;
    logic [DATA_W-1:0]       fwd_rs_data;
    logic [DATA_W-1:0]       fwd_rt_data;
    logic [3:0]              fwd_rs_sel;
    logic [3:0]              fwd_rt_sel;
    logic [CNT_W-1:0]        stall_count;

    modport master (
        output issue_valid, issue_rd, issue_we, issue_is_load,
        output rs_addr, rt_addr, rs_used, rt_used,
        output rf_rs_data, rf_rt_data, stage_data, flush,
        input  stall, fwd_rs_data, fwd_rt_data, fwd_rs_sel, fwd_rt_sel,
        input  stall_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_we, issue_is_load,
        input  rs_addr, rt_addr, rs_used, rt_used,
        input  rf_rs_data, rf_rt_data, stage_data, flush,
        output stall, fwd_rs_data, fwd_rt_data, fwd_rs_sel, fwd_rt_sel,
        output stall_count
    );
endinterface

// File: rtl/hazard_tracker.sv
// ---------------------------------------------------------------------------
// hazard_tracker -- scoreboard of in-flight destination registers for a
// simple in-order pipeline. Produces operand forwarding selects/data for the
// instruction in decode and a one-cycle load-use stall.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset (clears entries and stall counter)
//   hif   : hazard_if.slave
//           in : issue_valid/rd/we/is_load, rs/rt addr+used, rf_rs/rt_data,
//                stage_data (entry k at [k*DATA_W +: DATA_W]), flush
//           out: stall, fwd_rs/rt_data, fwd_rs/rt_sel (0 = RF, k+1 = entry k),
//                stall_count (saturating)
// ---------------------------------------------------------------------------
module hazard_tracker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input logic     clk,
    input logic     rst_n,
    hazard_if.slave hif
);
    // Entry 0 is the youngest in-flight instruction (EXE/MEM).
    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  ent_we;
    logic [ADDR_W-1:0] ent_rd [DEPTH];
    // Only entry 0 can cause a stall; once a load has moved past entry 0 its
    // result is forwardable, so the load flag is kept for entry 0 alone.
    logic              ld_p0;

    logic [DEPTH-1:0]  rs_hit;
    logic [DEPTH-1:0]  rt_hit;
    logic              stall_c;
    logic              issue_acc;
    logic [3:0]        rs_sel;
    logic [3:0]        rt_sel;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [CNT_W-1:0]  cnt_q;

    // Source match per entry; register 0 never matches.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rs_hit[k] = ent_vld[k] && ent_we[k] && (ent_rd[k] == hif.rs_addr)
                        && (hif.rs_addr != '0) && hif.rs_used;
            rt_hit[k] = ent_vld[k] && ent_we[k] && (ent_rd[k] == hif.rt_addr)
                        && (hif.rt_addr != '0) && hif.rt_used;
        end
    end

    // Forwarding mux: scan oldest to youngest so the youngest match is the
    // last assignment and therefore wins.
    always_comb begin
        rs_sel  = 4'd0;
        rt_sel  = 4'd0;
        rs_data = hif.rf_rs_data;
        rt_data = hif.rf_rt_data;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs_hit[k]) begin
                rs_sel  = 4'(k + 1);
                rs_data = hif.stage_data[k*DATA_W +: DATA_W];
            end
            if (rt_hit[k]) begin
                rt_sel  = 4'(k + 1);
                rt_data = hif.stage_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // A load in entry 0 delivers its result one stage too late for the
    // instruction in decode; a flushed decode slot never stalls.
    assign stall_c   = hif.issue_valid && !hif.flush && ld_p0 && (rs_hit[0] || rt_hit[0]);
    assign issue_acc = hif.issue_valid && !stall_c && !hif.flush;

    assign hif.stall       = stall_c;
    assign hif.fwd_rs_sel  = rs_sel;
    assign hif.fwd_rt_sel  = rt_sel;
    assign hif.fwd_rs_data = rs_data;
    assign hif.fwd_rt_data = rt_data;
    assign hif.stall_count = cnt_q;

    // Shift pipeline: entry 0 takes the issued instruction or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_vld <= '0;
            ent_we  <= '0;
            ld_p0   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                ent_rd[k] <= '0;
            end
            cnt_q   <= '0;
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                ent_vld[k] <= ent_vld[k-1];
                ent_we[k]  <= ent_we[k-1];
                ent_rd[k]  <= ent_rd[k-1];
            end
            ent_vld[0] <= issue_acc;
            ent_we[0]  <= issue_acc && hif.issue_we;
            ent_rd[0]  <= issue_acc ? hif.issue_rd : '0;
            ld_p0      <= issue_acc && hif.issue_is_load;
            if (stall_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_hazard_tracker.sv
// ---------------------------------------------------------------------------
// tb_hazard_tracker -- directed bench for hazard_tracker. Two instances:
// u_dut (DEPTH=3, CNT_W=16) and u_dut1 (DEPTH=1, CNT_W=2) sharing clk/rst_n.
// ---------------------------------------------------------------------------
module tb_hazard_tracker;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   sc_exp;

    hazard_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(3), .CNT_W(16)) hif ();
    hazard_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1), .CNT_W(2))  hif1 ();

    hazard_tracker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(3), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif.slave)
    );

    hazard_tracker #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1), .CNT_W(2)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        hif.issue_valid   = 1'b0;
        hif.issue_rd      = '0;
        hif.issue_we      = 1'b0;
        hif.issue_is_load = 1'b0;
        hif.rs_addr       = '0;
        hif.rt_addr       = '0;
        hif.rs_used       = 1'b0;
        hif.rt_used       = 1'b0;
        hif.rf_rs_data    = 32'h1111_0000;
        hif.rf_rt_data    = 32'h2222_0000;
        hif.stage_data    = {32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
        hif.flush         = 1'b0;
        hif1.issue_valid   = 1'b0;
        hif1.issue_rd      = '0;
        hif1.issue_we      = 1'b0;
        hif1.issue_is_load = 1'b0;
        hif1.rs_addr       = '0;
        hif1.rt_addr       = '0;
        hif1.rs_used       = 1'b0;
        hif1.rt_used       = 1'b0;
        hif1.rf_rs_data    = 32'h3333_0000;
        hif1.rf_rt_data    = 32'h4444_0000;
        hif1.stage_data    = 32'hD0D0_D0D0;
        hif1.flush         = 1'b0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic ld);
        hif.issue_valid   = 1'b1;
        hif.issue_rd      = rd;
        hif.issue_we      = 1'b1;
        hif.issue_is_load = ld;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        hif.rs_addr = 5'd3;
        hif.rs_used = 1'b1;
        hif.rf_rs_data = 32'h0000_AAAA;
        repeat (2) step();
        #2;
        checks++;
        if (hif.stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall got=%0h exp=0", hif.stall);
        end
        checks++;
        if (hif.fwd_rs_sel !== 4'd0 || hif.fwd_rs_data !== 32'h0000_AAAA) begin
            failures++; $display("FAIL reset_rs got sel=%0d data=%0h exp sel=0 data=aaaa",
                                 hif.fwd_rs_sel, hif.fwd_rs_data);
        end
        checks++;
        if (hif.stall_count !== 16'd0 || hif1.stall_count !== 2'd0) begin
            failures++; $display("FAIL reset_count got=%0d/%0d exp=0/0",
                                 hif.stall_count, hif1.stall_count);
        end
        step();
        rst_n = 1'b1;
        clear_inputs();
    endtask

    task automatic test_fwd_entry0();
        clear_inputs();
        issue(5'd1, 1'b0);
        step();
        hif.issue_valid = 1'b0;
        hif.rs_addr = 5'd1;
        hif.rs_used = 1'b1;
        hif.rf_rs_data = 32'h99;
        hif.stage_data = {32'hC2, 32'hB1, 32'd5};
        hif.rt_addr = 5'd2;
        hif.rt_used = 1'b1;
        #2;
        checks++;
        if (hif.fwd_rs_sel !== 4'd1 || hif.fwd_rs_data !== 32'd5 || hif.stall !== 1'b0) begin
            failures++; $display("FAIL fwd_e0 got sel=%0d data=%0h stall=%0b exp sel=1 data=5 stall=0",
                                 hif.fwd_rs_sel, hif.fwd_rs_data, hif.stall);
        end
        checks++;
        if (hif.fwd_rt_sel !== 4'd0 || hif.fwd_rt_data !== 32'h2222_0000) begin
            failures++; $display("FAIL fwd_e0_rt_pass got sel=%0d data=%0h exp sel=0 data=22220000",
                                 hif.fwd_rt_sel, hif.fwd_rt_data);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_fwd_priority();
        clear_inputs();
        issue(5'd10, 1'b0);
        step();
        issue(5'd11, 1'b0);
        step();
        hif.issue_valid = 1'b0;
        hif.rt_addr = 5'd10;
        hif.rt_used = 1'b1;
        hif.stage_data = {32'hC2, 32'h6E, 32'h11};
        #2;
        checks++;
        if (hif.fwd_rt_sel !== 4'd2 || hif.fwd_rt_data !== 32'h6E) begin
            failures++; $display("FAIL fwd_e1 got sel=%0d data=%0h exp sel=2 data=6e",
                                 hif.fwd_rt_sel, hif.fwd_rt_data);
        end
        // Issue rd=10 again: entries become {10, 11, 10}.
        issue(5'd10, 1'b0);
        step();
        hif.issue_valid = 1'b0;
        #2;
        checks++;
        if (hif.fwd_rt_sel !== 4'd1 || hif.fwd_rt_data !== 32'h11) begin
            failures++; $display("FAIL fwd_youngest got sel=%0d data=%0h exp sel=1 data=11",
                                 hif.fwd_rt_sel, hif.fwd_rt_data);
        end
        step();
        #2;
        checks++;
        if (hif.fwd_rt_sel !== 4'd2 || hif.fwd_rt_data !== 32'h6E) begin
            failures++; $display("FAIL fwd_e1_again got sel=%0d data=%0h exp sel=2 data=6e",
                                 hif.fwd_rt_sel, hif.fwd_rt_data);
        end
        step();
        #2;
        checks++;
        if (hif.fwd_rt_sel !== 4'd3 || hif.fwd_rt_data !== 32'hC2) begin
            failures++; $display("FAIL fwd_e2 got sel=%0d data=%0h exp sel=3 data=c2",
                                 hif.fwd_rt_sel, hif.fwd_rt_data);
        end
        step();
        #2;
        checks++;
        if (hif.fwd_rt_sel !== 4'd0 || hif.fwd_rt_data !== 32'h2222_0000) begin
            failures++; $display("FAIL fwd_drained got sel=%0d data=%0h exp sel=0 data=22220000",
                                 hif.fwd_rt_sel, hif.fwd_rt_data);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        issue(5'd4, 1'b1);
        step();
        // Load in entry 0 but nothing issuing: no stall.
        hif.issue_valid = 1'b0;
        hif.rs_addr = 5'd4;
        hif.rs_used = 1'b1;
        #2;
        checks++;
        if (hif.stall !== 1'b0) begin
            failures++; $display("FAIL load_no_issue got stall=%0b exp 0", hif.stall);
        end
        issue(5'd5, 1'b0);
        #1;
        checks++;
        if (hif.stall !== 1'b1 || hif.fwd_rs_sel !== 4'd1) begin
            failures++; $display("FAIL load_use_stall got stall=%0b sel=%0d exp stall=1 sel=1",
                                 hif.stall, hif.fwd_rs_sel);
        end
        step();
        sc_exp++;
        #2;
        checks++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_sel !== 4'd2 || hif.fwd_rs_data !== 32'hB1B1_B1B1) begin
            failures++; $display("FAIL load_after got stall=%0b sel=%0d data=%0h exp stall=0 sel=2 data=b1b1b1b1",
                                 hif.stall, hif.fwd_rs_sel, hif.fwd_rs_data);
        end
        checks++;
        if (hif.stall_count !== 16'(sc_exp)) begin
            failures++; $display("FAIL load_count got=%0d exp=%0d", hif.stall_count, sc_exp);
        end
        step();
        // The held instruction (rd=5) was accepted on the edge after the stall.
        hif.issue_valid = 1'b0;
        hif.rs_addr = 5'd5;
        #2;
        checks++;
        if (hif.fwd_rs_sel !== 4'd1) begin
            failures++; $display("FAIL load_reissue got sel=%0d exp 1", hif.fwd_rs_sel);
        end
        // Load-use through rt.
        clear_inputs();
        issue(5'd6, 1'b1);
        step();
        issue(5'd9, 1'b0);
        hif.rt_addr = 5'd6;
        hif.rt_used = 1'b1;
        #2;
        checks++;
        if (hif.stall !== 1'b1) begin
            failures++; $display("FAIL load_use_rt got stall=%0b exp 1", hif.stall);
        end
        step();
        sc_exp++;
        hif.issue_valid = 1'b0;
        #2;
        checks++;
        if (hif.stall_count !== 16'(sc_exp)) begin
            failures++; $display("FAIL load_rt_count got=%0d exp=%0d", hif.stall_count, sc_exp);
        end
        repeat (3) step();
        clear_inputs();
    endtask

    task automatic test_reg0();
        clear_inputs();
        issue(5'd0, 1'b0);
        step();
        hif.issue_valid = 1'b0;
        hif.rs_addr = 5'd0;
        hif.rs_used = 1'b1;
        hif.rf_rs_data = 32'd0;
        hif.stage_data = {32'h77, 32'h77, 32'h77};
        #2;
        checks++;
        if (hif.fwd_rs_sel !== 4'd0 || hif.fwd_rs_data !== 32'd0 || hif.stall !== 1'b0) begin
            failures++; $display("FAIL reg0_fwd got sel=%0d data=%0h stall=%0b exp 0/0/0",
                                 hif.fwd_rs_sel, hif.fwd_rs_data, hif.stall);
        end
        issue(5'd0, 1'b1);
        step();
        issue(5'd3, 1'b0);
        #2;
        checks++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_sel !== 4'd0) begin
            failures++; $display("FAIL reg0_load got stall=%0b sel=%0d exp 0/0",
                                 hif.stall, hif.fwd_rs_sel);
        end
        step();
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_flush();
        clear_inputs();
        issue(5'd7, 1'b1);
        step();
        issue(5'd9, 1'b0);
        hif.rs_addr = 5'd7;
        hif.rs_used = 1'b1;
        hif.flush = 1'b1;
        #2;
        checks++;
        if (hif.stall !== 1'b0) begin
            failures++; $display("FAIL flush_stall got=%0b exp 0", hif.stall);
        end
        step();
        hif.issue_valid = 1'b0;
        hif.flush = 1'b0;
        hif.rt_addr = 5'd9;
        hif.rt_used = 1'b1;
        #2;
        checks++;
        if (hif.fwd_rs_sel !== 4'd2 || hif.fwd_rt_sel !== 4'd0) begin
            failures++; $display("FAIL flush_bubble got rs_sel=%0d rt_sel=%0d exp 2/0",
                                 hif.fwd_rs_sel, hif.fwd_rt_sel);
        end
        checks++;
        if (hif.stall_count !== 16'(sc_exp)) begin
            failures++; $display("FAIL flush_count got=%0d exp=%0d", hif.stall_count, sc_exp);
        end
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        issue(5'd7, 1'b1);
        step();
        issue(5'd8, 1'b0);
        hif.rs_addr = 5'd7;
        hif.rs_used = 1'b1;
        #1;
        checks++;
        if (hif.stall !== 1'b1) begin
            failures++; $display("FAIL rst_pre_stall got=%0b exp 1", hif.stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (hif.stall !== 1'b0 || hif.fwd_rs_sel !== 4'd0 || hif.fwd_rs_data !== 32'h1111_0000) begin
            failures++; $display("FAIL rst_mid_stall got stall=%0b sel=%0d data=%0h exp 0/0/11110000",
                                 hif.stall, hif.fwd_rs_sel, hif.fwd_rs_data);
        end
        checks++;
        if (hif.stall_count !== 16'd0) begin
            failures++; $display("FAIL rst_count got=%0d exp=0", hif.stall_count);
        end
        sc_exp = 0;
        step();
        rst_n = 1'b1;
        // First edge after release accepts rd=8 normally.
        step();
        hif.issue_valid = 1'b0;
        hif.rs_addr = 5'd8;
        #2;
        checks++;
        if (hif.fwd_rs_sel !== 4'd1 || hif.stall !== 1'b0) begin
            failures++; $display("FAIL rst_release_issue got sel=%0d stall=%0b exp 1/0",
                                 hif.fwd_rs_sel, hif.stall);
        end
        clear_inputs();
        repeat (3) step();
    endtask

    task automatic test_depth1();
        clear_inputs();
        hif1.issue_valid = 1'b1;
        hif1.issue_rd = 5'd2;
        hif1.issue_we = 1'b1;
        step();
        hif1.issue_valid = 1'b0;
        hif1.rs_addr = 5'd2;
        hif1.rs_used = 1'b1;
        hif1.stage_data = 32'h55;
        #2;
        checks++;
        if (hif1.fwd_rs_sel !== 4'd1 || hif1.fwd_rs_data !== 32'h55) begin
            failures++; $display("FAIL d1_fwd got sel=%0d data=%0h exp 1/55",
                                 hif1.fwd_rs_sel, hif1.fwd_rs_data);
        end
        for (int i = 0; i < 5; i++) begin
            hif1.issue_valid = 1'b1;
            hif1.issue_rd = 5'd3;
            hif1.issue_is_load = 1'b1;
            hif1.rs_used = 1'b0;
            step();
            hif1.issue_is_load = 1'b0;
            hif1.issue_rd = 5'd9;
            hif1.rs_addr = 5'd3;
            hif1.rs_used = 1'b1;
            #2;
            checks++;
            if (hif1.stall !== 1'b1) begin
                failures++; $display("FAIL d1_stall_%0d got=%0b exp 1", i, hif1.stall);
            end
            step();
        end
        hif1.issue_valid = 1'b0;
        #2;
        checks++;
        if (hif1.stall !== 1'b0 || hif1.fwd_rs_sel !== 4'd0) begin
            failures++; $display("FAIL d1_after got stall=%0b sel=%0d exp 0/0",
                                 hif1.stall, hif1.fwd_rs_sel);
        end
        checks++;
        if (hif1.stall_count !== 2'd3) begin
            failures++; $display("FAIL d1_sat got=%0d exp=3", hif1.stall_count);
        end
        clear_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sc_exp   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        test_reset();
        test_fwd_entry0();
        test_fwd_priority();
        test_load_use();
        test_reg0();
        test_flush();
        test_reset_mid_stall();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
